// File: rtl/bist_pkg.sv
// Shared constants and the controller state type for the BIST pattern transmitter.
package bist_pkg;

    localparam int LFSR_WIDTH = 32;
    localparam int CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1, synchronously reloaded with SEED.
module lfsr32
    import bist_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = 32'hdeadbeef
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [LFSR_WIDTH-1:0] n
);

    logic w_feedback;

    assign w_feedback = n[31] ^ n[21] ^ n[1] ^ n[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            n <= SEED;
        end else begin
            n <= {n[LFSR_WIDTH-2:0], w_feedback};
        end
    end

endmodule

// File: rtl/bist_transmitter.sv
// BIST pattern transmitter: shifts TEST_CASES LFSR words into a TEST_CHANNELS-wide bus.
// Optional macro BIST_ERROR_INJECT_EN adds inject_error, which flips bit 0 of the word shifted in.
module bist_transmitter
    import bist_pkg::*;
#(
    parameter int                    TEST_CHANNELS = 70,
    parameter logic [LFSR_WIDTH-1:0] SEED          = 32'hdeadbeef,
    parameter int                    TEST_CASES    = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [TEST_CHANNELS-1:0] output_channels,
    output logic                     busy,
    output logic                     done
`ifdef BIST_ERROR_INJECT_EN
    ,
    input  logic                     inject_error
`endif
);

    localparam logic [CNT_WIDTH-1:0] LP_CASES = CNT_WIDTH'(TEST_CASES);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_WIDTH-1:0]     r_count;
    logic [CNT_WIDTH-1:0]     w_count_inc;
    logic [TEST_CHANNELS-1:0] r_out;
    logic [TEST_CHANNELS-1:0] w_out_shifted;
    logic [LFSR_WIDTH-1:0]    w_lfsr;
    logic [LFSR_WIDTH-1:0]    w_word;
    logic                     w_lfsr_reset;

    // The LFSR sits at SEED outside RUN, so every run starts from the same sequence.
    assign w_lfsr_reset = reset | (r_state != RUN);

    lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (w_lfsr_reset),
        .n     (w_lfsr)
    );

`ifdef BIST_ERROR_INJECT_EN
    assign w_word = w_lfsr ^ {{(LFSR_WIDTH-1){1'b0}}, inject_error};
`else
    assign w_word = w_lfsr;
`endif

    assign w_count_inc   = r_count + CNT_WIDTH'(1);
    // Concatenation then truncation: (out << 32) | word, sized to the bus for any width.
    assign w_out_shifted = TEST_CHANNELS'({r_out, w_word});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = (LP_CASES == '0) ? DONE : RUN;
            RUN:  if (w_count_inc == LP_CASES) w_state_next = DONE;
            DONE: if (!start) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_out   <= '0;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_out   <= w_out_shifted;
                    r_count <= w_count_inc;
                end
                default: ;
            endcase
        end
    end

    assign output_channels = r_out;

endmodule

// File: tb/tb_bist_transmitter.sv
// Self-checking bench for bist_transmitter: directed vector table, reset/restart sequences, random stimulus vs model.
module tb_bist_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        inj;
    logic [69:0] a_out;
    logic        a_busy, a_done;
    logic [19:0] c_out;
    logic        c_busy, c_done;
    logic [69:0] z_out;
    logic        z_busy, z_done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bist_transmitter #(.TEST_CHANNELS(70), .SEED(32'h1), .TEST_CASES(4)) dut_a (
        .clk(clk), .reset(rst), .start(start),
        .output_channels(a_out), .busy(a_busy), .done(a_done)
`ifdef BIST_ERROR_INJECT_EN
        , .inject_error(inj)
`endif
    );

    bist_transmitter #(.TEST_CHANNELS(20), .SEED(32'hdeadbeef), .TEST_CASES(5)) dut_c (
        .clk(clk), .reset(rst), .start(start),
        .output_channels(c_out), .busy(c_busy), .done(c_done)
`ifdef BIST_ERROR_INJECT_EN
        , .inject_error(inj)
`endif
    );

    bist_transmitter #(.TEST_CHANNELS(70), .SEED(32'h1), .TEST_CASES(0)) dut_z (
        .clk(clk), .reset(rst), .start(start),
        .output_channels(z_out), .busy(z_busy), .done(z_done)
`ifdef BIST_ERROR_INJECT_EN
        , .inject_error(inj)
`endif
    );

    typedef struct {
        bit          rst;
        bit          start;
        bit          a_busy;
        bit          a_done;
        logic [69:0] a_out;
        bit          z_done;
    } vec_t;

    // Behavioural model: run phase (0 idle, 1 running, 2 finished), updates done, bus value.
    typedef struct {
        int           mode;
        int           k;
        logic [127:0] out;
    } model_t;

    vec_t   vecs[8];
    model_t ma, mc, mz;

    function automatic logic [31:0] lfsr_at(logic [31:0] seed, int k);
        logic [31:0] v;
        v = seed;
        for (int i = 0; i < k; i++) v = {v[30:0], ^(v & 32'h8020_0003)};
        return v;
    endfunction

    function automatic logic [127:0] fold(logic [127:0] prev, logic [31:0] w, int width);
        logic [127:0] mask;
        mask = (128'd1 << width) - 128'd1;
        return ((prev << 32) | {96'd0, w}) & mask;
    endfunction

    function automatic model_t model_step(model_t m, bit r, bit st, bit ij, int cases, int width,
                                          logic [31:0] seed);
        model_t nx;
        nx = m;
        if (r) begin
            nx.mode = 0; nx.k = 0; nx.out = '0;
        end else if (m.mode == 0) begin
            if (st) begin
                nx.out = '0; nx.k = 0; nx.mode = (cases == 0) ? 2 : 1;
            end
        end else if (m.mode == 1) begin
            nx.out = fold(m.out, lfsr_at(seed, m.k) ^ {31'd0, ij}, width);
            nx.k   = m.k + 1;
            if (nx.k == cases) nx.mode = 2;
        end else begin
            if (!st) nx.mode = 0;
        end
        return nx;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] o1, o2, o3, o4;

    initial begin
        rst = 1'b1; start = 1'b0; inj = 1'b0;
        o1 = fold('0, lfsr_at(32'h1, 0), 70);
        o2 = fold(o1, lfsr_at(32'h1, 1), 70);
        o3 = fold(o2, lfsr_at(32'h1, 2), 70);
        o4 = fold(o3, lfsr_at(32'h1, 3), 70);

        //          rst   start busy  done  out            z_done
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 70'd0,         1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 70'd0,         1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, o1[69:0],      1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, o2[69:0],      1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, o3[69:0],      1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, o4[69:0],      1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, o4[69:0],      1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 70'd0,         1'b1};

        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst; start = vecs[i].start;
            tick();
            check($sformatf("vec%0d busy", i), {127'd0, a_busy}, {127'd0, vecs[i].a_busy});
            check($sformatf("vec%0d done", i), {127'd0, a_done}, {127'd0, vecs[i].a_done});
            check($sformatf("vec%0d out", i), {58'd0, a_out}, {58'd0, vecs[i].a_out});
            check($sformatf("vec%0d zero_cases done", i), {127'd0, z_done}, {127'd0, vecs[i].z_done});
            check($sformatf("vec%0d zero_cases busy", i), {127'd0, z_busy}, 128'd0);
            check($sformatf("vec%0d zero_cases out", i), {58'd0, z_out}, 128'd0);
        end

        // Reset on the third RUN cycle, then a full rerun from SEED.
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrun reset busy", {127'd0, a_busy}, 128'd0);
        check("midrun reset done", {127'd0, a_done}, 128'd0);
        check("midrun reset out", {58'd0, a_out}, 128'd0);
        rst = 1'b0; start = 1'b1;
        tick();
        check("restart busy", {127'd0, a_busy}, 128'd1);
        start = 1'b0;
        tick();
        check("restart word0", {58'd0, a_out}, o1);
        tick();
        check("restart word1", {58'd0, a_out}, o2);
        tick(); tick();
        check("restart done", {127'd0, a_done}, 128'd1);
        check("restart final out", {58'd0, a_out}, o4);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("done hold %0d done", i), {127'd0, a_done}, 128'd1);
            check($sformatf("done hold %0d busy", i), {127'd0, a_busy}, 128'd0);
            check($sformatf("done hold %0d out", i), {58'd0, a_out}, o4);
        end

        // Random stimulus against the model for all three configurations.
        rst = 1'b1; start = 1'b0;
        ma = '{0, 0, '0}; mc = '{0, 0, '0}; mz = '{0, 0, '0};
        tick();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst   = ($urandom_range(0, 49) == 0);
            start = ($urandom_range(0, 3) != 0);
`ifdef BIST_ERROR_INJECT_EN
            inj   = ($urandom_range(0, 7) == 0);
`endif
            ma = model_step(ma, rst, start, inj, 4, 70, 32'h1);
            mc = model_step(mc, rst, start, inj, 5, 20, 32'hdeadbeef);
            mz = model_step(mz, rst, start, inj, 0, 70, 32'h1);
            tick();
            check($sformatf("rand%0d a busy", cyc), {127'd0, a_busy}, {127'd0, ma.mode == 1});
            check($sformatf("rand%0d a done", cyc), {127'd0, a_done}, {127'd0, ma.mode == 2});
            check($sformatf("rand%0d a out", cyc), {58'd0, a_out}, ma.out);
            check($sformatf("rand%0d c busy", cyc), {127'd0, c_busy}, {127'd0, mc.mode == 1});
            check($sformatf("rand%0d c done", cyc), {127'd0, c_done}, {127'd0, mc.mode == 2});
            check($sformatf("rand%0d c out", cyc), {108'd0, c_out}, mc.out);
            check($sformatf("rand%0d z busy", cyc), {127'd0, z_busy}, {127'd0, mz.mode == 1});
            check($sformatf("rand%0d z done", cyc), {127'd0, z_done}, {127'd0, mz.mode == 2});
            check($sformatf("rand%0d z out", cyc), {58'd0, z_out}, mz.out);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bist_transmitter.md
BIST_TRANSMITTER -- requirements
Module: bist_transmitter

Interface
REQ-001 SHALL have parameter TEST_CHANNELS, default 70, giving the width of the driven test bus.
REQ-002 SHALL have parameter SEED, default 32'hdeadbeef, giving the LFSR seed.
REQ-003 SHALL have parameter TEST_CASES, default 1000, giving the number of patterns per run.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: level request to begin a run, sampled in IDLE and DONE.
REQ-007 SHALL have port output_channels, output, TEST_CHANNELS bits: pattern bus, driven directly from a register.
REQ-008 SHALL have port busy, output, 1 bit: high exactly while the state is RUN.
REQ-009 SHALL have port done, output, 1 bit: high exactly while the state is DONE.

Function
REQ-010 SHALL implement the states IDLE, RUN and DONE.
REQ-011 IDLE with start=1 SHALL on the next edge set the state to RUN, clear output_channels to 0 and clear the 32-bit case counter to 0.
REQ-012 IDLE with start=1 and TEST_CASES=0 SHALL go directly to DONE, with output_channels cleared to 0.
REQ-013 In RUN, each edge SHALL perform output_channels <= ((output_channels << 32) | lfsr_value), truncated to TEST_CHANNELS bits, and SHALL increment the counter.
REQ-014 lfsr_value SHALL be zero-extended when TEST_CHANNELS exceeds 32 and truncated when it is below 32.
REQ-015 RUN SHALL go to DONE on the edge where the counter reaches TEST_CASES, giving exactly TEST_CASES updates and busy high for exactly TEST_CASES cycles.
REQ-016 The LFSR SHALL be held at SEED whenever the state is not RUN, so the first RUN word equals SEED.
REQ-017 The LFSR SHALL advance exactly once per RUN cycle, making the sequence identical to a receiver's expected sequence from reset.
REQ-018 In DONE, output_channels SHALL hold its last value.
REQ-019 DONE with start=0 SHALL go to IDLE; DONE with start=1 SHALL remain in DONE, so a run needs start low then high.
REQ-020 start SHALL be ignored while in RUN.
REQ-021 In IDLE, output_channels SHALL hold its value until a new run begins.

Reset
REQ-022 reset=1 SHALL on the next edge set the state to IDLE, the counter to 0, output_channels to 0, busy to 0, done to 0 and the LFSR to SEED.
REQ-023 reset SHALL take priority over start and over all state transitions, including when asserted mid-RUN; there SHALL be no partial-run resumption.

Configuration
REQ-024 With BIST_ERROR_INJECT_EN defined, the block SHALL add input port inject_error (1 bit).
REQ-025 With BIST_ERROR_INJECT_EN defined, inject_error=1 during a RUN cycle SHALL invert bit 0 of the word shifted in on that edge.
REQ-026 The inversion SHALL be one-shot per assertion cycle and SHALL leave the LFSR sequence unaffected.
REQ-027 inject_error SHALL be ignored outside RUN.
REQ-028 Without BIST_ERROR_INJECT_EN, the inject_error port SHALL be absent and the pattern SHALL be pure LFSR data.

Structure
REQ-029 Package bist_pkg SHALL hold the localparam LFSR_WIDTH=32, the state enum typedef (IDLE, RUN, DONE) and the counter width constant.
REQ-030 The existing lfsr32 module (parameter SEED; ports clk, reset, n) SHALL be the sole sub-module.
REQ-031 The lfsr32 instance reset SHALL be driven by reset OR (state != RUN).

Verification
REQ-032 TEST_CASES=4, SEED=32'h1, TEST_CHANNELS=70: reset, then start=1 for 1 cycle -> after the first RUN edge output_channels=70'h1; busy is high for exactly 4 cycles, then done=1.
REQ-033 Second RUN edge -> output_channels = (70'h1 << 32) | the second lfsr32 value; the upper bits are truncated correctly at width 70.
REQ-034 Transmitter connected back-to-back to a BIST receiver with the same SEED/TEST_CASES, both reset together and start held high -> receiver failed=0 at completion.
REQ-035 reset asserted on the third RUN cycle -> the next cycle has state IDLE, output_channels=0, busy=0, done=0; a subsequent start reproduces the identical sequence from SEED.
REQ-036 TEST_CASES=0, start=1 -> done=1 on the next cycle, busy never high, output_channels=0.
REQ-037 BIST_ERROR_INJECT_EN defined, inject_error pulsed on RUN cycle 2 -> exactly one word has bit 0 flipped and the connected receiver reports failed=1; start held high in DONE keeps done=1 with no restart.
